// File: rtl/motor_fault_monitor_pkg.sv
// Shared types and helpers for the motor fault monitor.
// State encodings are fixed so that debug probes and the controller agree on them.
package motor_fault_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SPINUP = 2'd1,
    ST_RUN    = 2'd2,
    ST_FAULT  = 2'd3
  } mot_state_e;

  function automatic int timer_width(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/motor_fault_monitor_channel.sv
// One motor channel: input synchronisers, over-current debounce, watchdog timer
// and the supervision FSM.
//   state  | meaning
//   IDLE   | drive off, waiting for a run request
//   SPINUP | drive on, waiting for the first tach edge
//   RUN    | drive on, tach edges arriving in time
//   FAULT  | drive off, fault latched until cleared while disabled
module motor_fault_monitor_channel
  import motor_fault_monitor_pkg::*;
#(
  parameter int SPINUP_CYC  = 1000,
  parameter int TACH_TO_CYC = 200,
  parameter int DEB_CYC     = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_mot_ena,
  input  logic i_tach,
  input  logic i_ovc_n,
  input  logic i_err_clr,
  output logic o_drv_ena,
  output logic o_mot_run,
  output logic o_mot_err
);

  localparam int TW = timer_width(SPINUP_CYC, TACH_TO_CYC);
  localparam int DW = $clog2(DEB_CYC + 1);

  logic          r_tach_s1, r_tach_s2, r_tach_d, r_tach_edge;
  logic          r_ovc_s1, r_ovc_s2;
  logic [DW-1:0] r_deb_cnt;
  logic [TW-1:0] r_timer;
  mot_state_e    r_state;
  logic          r_drv_ena, r_mot_run, r_mot_err;
  logic          w_ovc, w_expired;

  assign w_ovc     = (r_deb_cnt == DW'(DEB_CYC));
  assign w_expired = (r_timer == '0);

  // Sync stages reset to the idle pin levels so release never fakes an event.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tach_s1   <= 1'b0;
      r_tach_s2   <= 1'b0;
      r_tach_d    <= 1'b0;
      r_tach_edge <= 1'b0;
      r_ovc_s1    <= 1'b1;
      r_ovc_s2    <= 1'b1;
      r_deb_cnt   <= '0;
    end else begin
      r_tach_s1   <= i_tach;
      r_tach_s2   <= r_tach_s1;
      r_tach_d    <= r_tach_s2;
      r_tach_edge <= r_tach_s2 & ~r_tach_d;
      r_ovc_s1    <= i_ovc_n;
      r_ovc_s2    <= r_ovc_s1;
      if (r_ovc_s2)   r_deb_cnt <= '0;
      else if (!w_ovc) r_deb_cnt <= r_deb_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_timer   <= '0;
      r_drv_ena <= 1'b0;
      r_mot_run <= 1'b0;
      r_mot_err <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_mot_ena) begin
            r_state   <= ST_SPINUP;
            r_timer   <= TW'(SPINUP_CYC);
            r_drv_ena <= 1'b1;
          end
        end
        ST_SPINUP, ST_RUN: begin
          // Fault sources outrank the disable so a fault is never dropped.
          if (w_ovc || w_expired) begin
            r_state   <= ST_FAULT;
            r_drv_ena <= 1'b0;
            r_mot_run <= 1'b0;
            r_mot_err <= 1'b1;
          end else if (!i_mot_ena) begin
            r_state   <= ST_IDLE;
            r_drv_ena <= 1'b0;
            r_mot_run <= 1'b0;
          end else if (r_tach_edge) begin
            r_state   <= ST_RUN;
            r_timer   <= TW'(TACH_TO_CYC);
            r_mot_run <= 1'b1;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        ST_FAULT: begin
          if (i_err_clr && !i_mot_ena) begin
            r_state   <= ST_IDLE;
            r_mot_err <= 1'b0;
          end
        end
      endcase
    end
  end

  assign o_drv_ena = r_drv_ena;
  assign o_mot_run = r_mot_run;
  assign o_mot_err = r_mot_err;

endmodule

// File: rtl/motor_fault_monitor.sv
// Motor-side MOT_ENA/MOT_ERR endpoint: one independent supervision channel per motor,
// with the fault clear request shared by all channels.
module motor_fault_monitor
  import motor_fault_monitor_pkg::*;
#(
  parameter int N_MOT       = 5,
  parameter int SPINUP_CYC  = 1000,
  parameter int TACH_TO_CYC = 200,
  parameter int DEB_CYC     = 4
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic [N_MOT-1:0] MOT_ENA,
  input  logic [N_MOT-1:0] TACH,
  input  logic [N_MOT-1:0] OVC_N,
  input  logic             ERR_CLR,
  output logic [N_MOT-1:0] DRV_ENA,
  output logic [N_MOT-1:0] MOT_RUN,
  output logic [N_MOT-1:0] MOT_ERR
);

  for (genvar g = 0; g < N_MOT; g++) begin : g_ch
    motor_fault_monitor_channel #(
      .SPINUP_CYC  (SPINUP_CYC),
      .TACH_TO_CYC (TACH_TO_CYC),
      .DEB_CYC     (DEB_CYC)
    ) u_ch (
      .i_clk     (CLK),
      .i_rst_n   (RSTn),
      .i_mot_ena (MOT_ENA[g]),
      .i_tach    (TACH[g]),
      .i_ovc_n   (OVC_N[g]),
      .i_err_clr (ERR_CLR),
      .o_drv_ena (DRV_ENA[g]),
      .o_mot_run (MOT_RUN[g]),
      .o_mot_err (MOT_ERR[g])
    );
  end

endmodule

// File: tb/tb_motor_fault_monitor.sv
// Bench for motor_fault_monitor: directed scenarios followed by random traffic,
// all checked against a cycle-level behavioural model built from pin histories.
module tb_motor_fault_monitor;

  localparam int N  = 5;
  localparam int SP = 20;
  localparam int TT = 10;
  localparam int DB = 4;

  logic         CLK = 1'b0;
  logic         RSTn;
  logic [N-1:0] MOT_ENA, TACH, OVC_N;
  logic         ERR_CLR;
  logic [N-1:0] DRV_ENA, MOT_RUN, MOT_ERR;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  motor_fault_monitor #(
    .N_MOT(N), .SPINUP_CYC(SP), .TACH_TO_CYC(TT), .DEB_CYC(DB)
  ) dut (
    .CLK(CLK), .RSTn(RSTn), .MOT_ENA(MOT_ENA), .TACH(TACH), .OVC_N(OVC_N),
    .ERR_CLR(ERR_CLR), .DRV_ENA(DRV_ENA), .MOT_RUN(MOT_RUN), .MOT_ERR(MOT_ERR)
  );

  // Model: per channel drive/run/fault flags, cycles since the watchdog was armed,
  // and the last 6 sampled pin values (index 0 = most recent edge).
  bit m_on[N], m_run[N], m_err[N];
  int m_age[N], m_lim[N];
  bit th[N][6], oh[N][6];
  int tper[N];
  int cyc = 0;
  int burst[N];

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_on[c] = 0; m_run[c] = 0; m_err[c] = 0; m_age[c] = 0; m_lim[c] = 0;
      for (int k = 0; k < 6; k++) begin th[c][k] = 0; oh[c][k] = 1; end
    end
  endtask

  // Tach edge reaches the FSM 3 edges after the pin rises; over-current needs
  // DB consecutive low samples, seen 3 edges after the last one.
  task automatic model_edge();
    for (int c = 0; c < N; c++) begin
      bit ev_t, ev_o, en;
      ev_t = th[c][2] && !th[c][3];
      ev_o = 1;
      for (int k = 2; k < 2 + DB; k++) if (oh[c][k]) ev_o = 0;
      en = MOT_ENA[c];
      if (m_err[c]) begin
        if (ERR_CLR && !en) m_err[c] = 0;
      end else if (!m_on[c]) begin
        if (en) begin m_on[c] = 1; m_age[c] = 0; m_lim[c] = SP; end
      end else begin
        m_age[c]++;
        if (ev_o || m_age[c] > m_lim[c]) begin
          m_on[c] = 0; m_run[c] = 0; m_err[c] = 1;
        end else if (!en) begin
          m_on[c] = 0; m_run[c] = 0;
        end else if (ev_t) begin
          m_run[c] = 1; m_age[c] = 0; m_lim[c] = TT;
        end
      end
      for (int k = 5; k > 0; k--) begin th[c][k] = th[c][k-1]; oh[c][k] = oh[c][k-1]; end
      th[c][0] = TACH[c];
      oh[c][0] = OVC_N[c];
    end
  endtask

  task automatic chk_vec(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [N-1:0] e_drv, e_run, e_err;
    for (int c = 0; c < N; c++) begin
      e_drv[c] = m_on[c]; e_run[c] = m_run[c]; e_err[c] = m_err[c];
    end
    chk_vec({tag, "_drv"}, DRV_ENA, e_drv);
    chk_vec({tag, "_run"}, MOT_RUN, e_run);
    chk_vec({tag, "_err"}, MOT_ERR, e_err);
  endtask

  task automatic step(input string tag);
    for (int c = 0; c < N; c++)
      if (tper[c] > 0) TACH[c] = ((cyc % tper[c]) < (tper[c] / 2));
    cyc++;
    @(posedge CLK);
    if (RSTn) model_edge();
    #1;
    check_model(tag);
  endtask

  initial begin
    RSTn = 1'b0; MOT_ENA = '0; TACH = '0; OVC_N = '1; ERR_CLR = 1'b0;
    for (int c = 0; c < N; c++) begin tper[c] = 0; burst[c] = 0; end
    model_reset();

    // 1: reset with toggling pins, then idle after release
    repeat (5) begin
      TACH = N'($urandom); OVC_N = N'($urandom);
      step("rst");
    end
    chk_vec("rst_drv0", DRV_ENA, '0);
    chk_vec("rst_err0", MOT_ERR, '0);
    TACH = '0; OVC_N = '1;
    step("rst");
    RSTn = 1'b1;
    model_reset();
    repeat (10) step("idle");
    chk_vec("idle_drv0", DRV_ENA, '0);

    // 2: normal run on motor 0
    MOT_ENA[0] = 1'b1;
    step("t2");
    chk_bit("t2_drv_lat", DRV_ENA[0], 1'b1);
    tper[0] = 8;
    repeat (200) step("t2");
    chk_bit("t2_running", MOT_RUN[0], 1'b1);
    chk_vec("t2_no_err", MOT_ERR, '0);

    // 3: stall on motor 2 during spin-up, then tach loss while running
    MOT_ENA[2] = 1'b1;
    step("t3");
    repeat (20) step("t3");
    chk_bit("t3_no_err_c20", MOT_ERR[2], 1'b0);
    step("t3");
    chk_bit("t3_err_c21", MOT_ERR[2], 1'b1);
    chk_bit("t3_drv_off", DRV_ENA[2], 1'b0);
    MOT_ENA[2] = 1'b0; ERR_CLR = 1'b1;
    step("t3");
    ERR_CLR = 1'b0;
    chk_bit("t3_cleared", MOT_ERR[2], 1'b0);
    MOT_ENA[2] = 1'b1; tper[2] = 6;
    repeat (30) step("t3");
    chk_bit("t3_running", MOT_RUN[2], 1'b1);
    tper[2] = 0; TACH[2] = 1'b0;
    repeat (20) step("t3");
    chk_bit("t3_tach_loss", MOT_ERR[2], 1'b1);

    // 4: over-current debounce on motor 4
    MOT_ENA[4] = 1'b1; tper[4] = 8;
    repeat (25) step("t4");
    OVC_N[4] = 1'b0;
    repeat (3) step("t4");
    OVC_N[4] = 1'b1;
    repeat (8) step("t4");
    chk_bit("t4_short_ovc", MOT_ERR[4], 1'b0);
    OVC_N[4] = 1'b0;
    repeat (4) step("t4");
    OVC_N[4] = 1'b1;
    repeat (6) step("t4");
    chk_bit("t4_ovc_fault", MOT_ERR[4], 1'b1);
    chk_bit("t4_ch0_err", MOT_ERR[0], 1'b0);
    chk_bit("t4_ch0_run", MOT_RUN[0], 1'b1);

    // 5: clear only honoured while disabled
    ERR_CLR = 1'b1;
    repeat (3) step("t5");
    chk_bit("t5_clr_ignored", MOT_ERR[4], 1'b1);
    MOT_ENA[4] = 1'b0;
    step("t5");
    chk_bit("t5_clr_taken", MOT_ERR[4], 1'b0);
    ERR_CLR = 1'b0; MOT_ENA[4] = 1'b1;
    step("t5");
    chk_bit("t5_respin_drv", DRV_ENA[4], 1'b1);
    chk_bit("t5_respin_run", MOT_RUN[4], 1'b0);

    // 6: over-current coinciding with disable, then async reset in RUN
    repeat (25) step("t6");
    OVC_N[4] = 1'b0;
    repeat (6) step("t6");
    MOT_ENA[4] = 1'b0;
    step("t6");
    chk_bit("t6_coinc_err", MOT_ERR[4], 1'b1);
    chk_bit("t6_coinc_drv", DRV_ENA[4], 1'b0);
    OVC_N[4] = 1'b1;
    step("t6");
    chk_bit("t6_pre_rst_run", MOT_RUN[0], 1'b1);
    #2 RSTn = 1'b0;
    #1;
    chk_vec("t6_arst_drv", DRV_ENA, '0);
    chk_vec("t6_arst_run", MOT_RUN, '0);
    chk_vec("t6_arst_err", MOT_ERR, '0);
    model_reset();
    #1 RSTn = 1'b1;
    repeat (30) step("t6");

    // random traffic
    for (int c = 0; c < N; c++) tper[c] = 0;
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(19) == 0) MOT_ENA[c] = ~MOT_ENA[c];
        if ($urandom_range(3) == 0) TACH[c] = ~TACH[c];
        if (burst[c] > 0) burst[c]--;
        else if ($urandom_range(59) == 0) burst[c] = $urandom_range(6, 1);
        OVC_N[c] = (burst[c] == 0);
      end
      ERR_CLR = ($urandom_range(15) == 0);
      step("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
